gate_response_checker: RTL
==========================

Name: gate_response_checker

Overview:
- Self-checking response end for the two-input NAND/NOR gate block (y[1] = NOR, y[0] = NAND).
- Captures each applied input vector (a, b) on a valid/ready handshake, waits a programmable settle time, then samples the gate outputs and compares them against the truth table.
- Keeps saturating pass/fail counts and coverage of the four input combinations, so simulation and FPGA builds report gate correctness without waveform inspection.

Parameters:
- CNT_W, 8, width of the pass and fail counters (saturating).
- SETTLE_CYC, 2, clock cycles between vector capture and output sampling; legal range 0..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset. All state clears immediately on assertion; release is synchronous to clk.
- in_valid  input  1  stimulus vector present on a, b.
- in_ready  output  1  checker can accept a vector; equals (state == IDLE).
- a  input  1  gate input a, as applied to the DUT.
- b  input  1  gate input b, as applied to the DUT.
- y  input  2  DUT outputs; y[1] = NOR, y[0] = NAND.
- clr  input  1  synchronous clear of counters, coverage and error flags; FSM state is unaffected.
- pass_cnt  output  CNT_W  matching compares.
- fail_cnt  output  CNT_W  mismatching compares.
- cov_mask  output  4  bit {a,b} set once that combination has been checked.
- all_covered  output  1  &cov_mask.
- err_pulse  output  1  one-cycle pulse on a mismatch.
- busy  output  1  ~in_ready.

Behaviour:
- Reset values: FSM = IDLE, in_ready = 1, busy = 0, pass_cnt = 0, fail_cnt = 0, cov_mask = 0, all_covered = 0, err_pulse = 0, internal capture registers = 0.
- FSM states: IDLE, SETTLE, CHECK.
- IDLE:
  - in_valid && in_ready at edge T: latch {a,b} into cap_ab, load wait counter with SETTLE_CYC, move to SETTLE.
  - If SETTLE_CYC == 0, go directly to CHECK.
- SETTLE: decrement wait counter each cycle; move to CHECK on the edge where the counter reaches 0.
- CHECK (lasts exactly one cycle):
  - Compute exp = {~(cap_ab[1] | cap_ab[0]), ~(cap_ab[1] & cap_ab[0])}.
  - Compare against y sampled this cycle.
  - At the exiting edge: update counters, set cov_mask[cap_ab], assert err_pulse for one cycle on mismatch, return to IDLE.
- Latency:
  - CHECK occupies cycle T+1+SETTLE_CYC.
  - Results are visible in cycle T+2+SETTLE_CYC.
  - in_ready reasserts in that same cycle.
  - Maximum throughput is one vector per SETTLE_CYC+2 cycles.
- in_valid while busy is ignored and not queued. a and b are don't-care after capture.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Any X/Z bit on y during CHECK counts as a mismatch; compare with case-equality semantics in simulation.
- clr in the same cycle as CHECK: clr wins, and the result of that check is discarded (counts and coverage stay 0). The FSM still returns to IDLE.
- cov_mask bits are sticky until clr or reset.
- rst_n asserted mid-operation: immediate return to reset values; the in-flight vector is discarded.

Optional Feature:
- Macro: GATE_CHECKER_FIRST_FAIL_EN.
- Defined:
  - Adds outputs first_fail_vld (1 bit), first_fail_ab (2 bits) and first_fail_y (2 bits).
  - On the first mismatch after reset or clr, these capture cap_ab and the sampled y, and first_fail_vld sets.
  - Later mismatches do not overwrite them.
  - clr and reset clear all three.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package gate_chk_pkg holds:
  - FSM state enum (IDLE, SETTLE, CHECK).
  - Localparam bit indices NOR_BIT = 1 and NAND_BIT = 0.
  - Function gate_expected(ab) returning the 2-bit expected vector, reused by any future gate checkers.
- One natural sub-module: sat_counter (width parameter; inc and clr inputs; saturating output). It is instantiated twice, for pass and fail.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> pass_cnt = 0, fail_cnt = 0, cov_mask = 0, in_ready = 1, and no capture occurs.
- Correct DUT, vectors 00, 01, 10, 11 with y = 11, 01, 01, 00 -> pass_cnt = 4, fail_cnt = 0, cov_mask = 4'b1111, all_covered = 1, err_pulse never asserted.
- Fault injection: vector 11 with y forced to 01 -> fail_cnt = 1 and err_pulse high for one cycle at T+4 (SETTLE_CYC = 2). With the macro defined: first_fail_ab = 11, first_fail_y = 01.
- Back-to-back in_valid held high for 10 cycles -> exactly one capture per 4 cycles (SETTLE_CYC = 2); in_ready is low during SETTLE and CHECK.
- SETTLE_CYC = 0 build: capture at T -> result visible at T+2. Also assert clr in the CHECK cycle -> counters stay 0.
- CNT_W = 2 build, 5 correct vectors -> pass_cnt saturates at 3 and does not wrap. rst_n pulsed low during SETTLE -> counters 0, FSM back in IDLE.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg
// Shared definitions for gate response checkers.
//   gate_state_t  : checker FSM state (IDLE, SETTLE, CHECK)
//   NOR_BIT/NAND_BIT : bit positions of the gate outputs in the y vector
//   gate_expected : truth table of the two-input NOR/NAND gate block
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2
    } gate_state_t;

    localparam int NOR_BIT  = 1;
    localparam int NAND_BIT = 0;

    // ab[1] = a, ab[0] = b. Returns {NOR, NAND}.
    function automatic logic [1:0] gate_expected(input logic [1:0] ab);
        logic [1:0] e;
        e           = '0;
        e[NOR_BIT]  = ~(ab[1] | ab[0]);
        e[NAND_BIT] = ~(ab[1] & ab[0]);
        return e;
    endfunction

endpackage

// File: rtl/gate_response_checker_if.sv
// gate_response_checker_if
// Stimulus/response bundle between the gate stimulus source and the checker.
//   in_valid : vector present on a, b
//   in_ready : checker can accept a vector
//   a, b     : gate inputs as applied to the gate under test
//   y        : gate outputs, y[1] = NOR, y[0] = NAND
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high. in_valid may be raised without waiting for
// in_ready; a, b are only looked at in the transfer cycle. in_valid while
// in_ready is low is ignored, nothing is queued.
interface gate_response_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       b;
    logic [1:0] y;

    modport master (output in_valid, output a, output b, output y, input in_ready);
    modport slave  (input in_valid, input a, input b, input y, output in_ready);
endinterface

// File: rtl/gate_response_checker_sat_counter.sv
// sat_counter
// Saturating up-counter: increments on inc, holds at all-ones, never wraps.
// clr (synchronous) has priority over inc.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event
//   clr        : synchronous clear to zero
//   count      : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// gate_response_checker
// Response end for the two-input NAND/NOR gate block. Captures a vector on
// the handshake, waits SETTLE_CYC cycles, compares y against the truth table
// and keeps saturating pass/fail counts plus coverage of the four inputs.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   gif (slave)    : in_valid/in_ready/a/b/y bundle
//   clr            : synchronous clear of counters, coverage, error flags
//   pass_cnt       : matching compares (saturating)
//   fail_cnt       : mismatching compares (saturating)
//   cov_mask       : bit {a,b} set once that combination has been checked
//   all_covered    : all four combinations checked
//   err_pulse      : one-cycle pulse after a mismatching check
//   busy           : ~in_ready
//   state_dbg      : current FSM state
// Optional (macro GATE_CHECKER_FIRST_FAIL_EN):
//   first_fail_vld/_ab/_y : vector and response of the first mismatch
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_response_checker_if.slave gif,
    input  logic                   clr,
    output logic [CNT_W-1:0]       pass_cnt,
    output logic [CNT_W-1:0]       fail_cnt,
    output logic [3:0]             cov_mask,
    output logic                   all_covered,
    output logic                   err_pulse,
    output logic                   busy,
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    output logic                   first_fail_vld,
    output logic [1:0]             first_fail_ab,
    output logic [1:0]             first_fail_y,
`endif
    output gate_state_t            state_dbg
);

    gate_state_t state;
    logic [3:0]  wait_cnt;
    logic [1:0]  cap_ab;
    logic        match;
    logic        in_check;

    // Case equality so any X/Z on y counts as a mismatch in simulation.
    assign match    = (gif.y === gate_expected(cap_ab));
    assign in_check = (state == CHECK);

    assign gif.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    assign all_covered  = &cov_mask;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_ab    <= '0;
            cov_mask  <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (gif.in_valid) begin
                        cap_ab   <= {gif.a, gif.b};
                        wait_cnt <= 4'(SETTLE_CYC);
                        state    <= (SETTLE_CYC == 0) ? CHECK : SETTLE;
                    end
                end
                SETTLE: begin
                    // Leaving on the edge where the count reaches zero keeps
                    // SETTLE exactly SETTLE_CYC cycles long.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!clr) begin
                        cov_mask[cap_ab] <= 1'b1;
                        err_pulse        <= ~match;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed after the case so a clear beats a same-cycle check.
            if (clr) begin
                cov_mask <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_check & match & ~clr),
        .clr   (clr),
        .count (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_check & ~match & ~clr),
        .clr   (clr),
        .count (fail_cnt)
    );

`ifdef GATE_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_ab  <= '0;
            first_fail_y   <= '0;
        end else if (clr) begin
            first_fail_vld <= 1'b0;
            first_fail_ab  <= '0;
            first_fail_y   <= '0;
        end else if (in_check && !match && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_ab  <= cap_ab;
            first_fail_y   <= gif.y;
        end
    end
`endif

endmodule
